shift_reg_seq_ctrl: RTL and testbench
=====================================

# shift_reg_seq_ctrl

Sequencer and two-port arbiter for the 4-bit shift register datapath. It accepts shift jobs from two requesters (parallel word, direction, shift count, fill bit) and arbitrates between them round-robin. For each granted job it drives the register's parallel-load, right/left-shift and serial-in controls cycle by cycle, then returns the final register contents with a one-cycle done pulse. It sits between the shift register and its client logic, so only one job owns the register at a time.

## Interface
- WIDTH, 4, register width; this spec is written for 4
- CNT_W, 3, width of the shift-count field

- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- req0_valid / req1_valid  in  1  job request per requester
- req0_ready / req1_ready  out  1  job accepted this cycle when valid&&ready
- req0_data / req1_data  in  WIDTH  word to parallel-load
- req0_dir / req1_dir  in  1  0 = shift right, 1 = shift left
- req0_cnt / req1_cnt  in  CNT_W  number of shifts; values >WIDTH clamp to WIDTH
- req0_fill / req1_fill  in  1  serial-in bit during shifts
- sr_l  out  WIDTH  parallel-load value to register
- sr_ld  out  1  parallel-load strobe
- sr_r  out  1  shift-right enable
- sr_lf  out  1  shift-left enable
- sr_d  out  1  serial-in bit
- sr_q  in  WIDTH  register output
- busy  out  1  job in progress (state != IDLE)
- done  out  1  one-cycle job-complete pulse
- done_id  out  1  requester that owned the completed job
- dout  out  WIDTH  sr_q sampled in DONE; held until the next DONE

## Operation
- Register semantics the controller targets:
  - right shift: q <= {d, q[3:1]}
  - left shift: q <= {q[2:0], d}
  - load: q <= l
  - at most one of sr_ld/sr_r/sr_lf is high in any cycle
- States are IDLE, LOAD, SHIFT and DONE.
  - IDLE: grant is combinational. If only one valid, grant it. If both valid, grant the requester selected by priority pointer `prio`. Only the granted requester sees ready=1. Ready is 0 in every other state.
  - Accept (valid&&ready): latch data, dir, clamped cnt, fill and id. `prio` becomes the other requester. Go to LOAD.
  - LOAD: sr_ld=1, sr_l=latched data. Go to SHIFT if cnt>0, else DONE. Remaining-count register is set to cnt.
  - SHIFT: sr_r=!dir, sr_lf=dir, sr_d=fill. Decrement remaining each cycle and exit to DONE after the cycle in which remaining becomes 0. There are exactly cnt shift cycles.
  - DONE: done=1, done_id=latched id, dout<=sr_q (the register value after the last load/shift). Go to IDLE.
- sr_l holds the latched data outside LOAD. sr_d is 0 outside SHIFT.
- Request fields are only sampled at accept; later changes are ignored.

## Timing
- Reset values:
  - state=IDLE, prio=0
  - all sr_* outputs 0, ready 0, busy 0, done 0, done_id 0, dout 0
- Latency: accept at edge T; LOAD in cycle T+1; shifts in T+2..T+1+cnt; done high in cycle T+2+cnt. cnt=0 gives done at T+2.
- Throughput: back to IDLE after DONE, so the next accept is possible in the cycle after done. The minimum job period is cnt+3 cycles.
- Simultaneous valids with prio=0: req0 granted, then req1 next. Strict alternation while both stay valid.
- A valid that arrives while busy waits. It is not dropped, and ready stays 0.
- rst mid-job has these effects:
  - next cycle is IDLE with all outputs at reset values
  - no done pulse
  - the job is discarded (requester must re-issue)
  - register contents are left as-is
- rst takes precedence over accept in the same cycle.

## Structure
- Shared package `shift_reg_pkg`:
  - state enum (IDLE, LOAD, SHIFT, DONE)
  - WIDTH default
  - DIR_RIGHT=0 / DIR_LEFT=1 constants
  - job struct {data, dir, cnt, fill, id}
- One natural sub-module: `rr_arb2`, a two-requester round-robin grant with a pointer update on accept. The FSM, job latch and counter stay in the top.
- The bench instantiates the real shift_reg_4b driven by sr_* so that dout is checked end-to-end.

## Test plan
- After reset, hold rst 3 cycles -> all outputs 0, ready both 0 while idle with no valid, prio=0.
- req0: data 4'b1011, dir right, cnt 2, fill 0 -> sr_ld 1 cycle, sr_r 2 cycles, done at T+4, done_id=0, dout=4'b0010.
- req1: data 4'b1011, dir left, cnt 1, fill 1 -> sr_lf 1 cycle, dout=4'b0111, done_id=1. With cnt 7, the count clamps to 4 shifts and dout=4'b1111.
- Both valid continuously with 4 jobs each -> grants alternate 0,1,0,1. No ready is asserted while busy, and no sr_ld/sr_r/sr_lf overlap.
- cnt 0, data 4'b0110 -> no shift cycles, done at T+2, dout=4'b0110.
- Assert rst during SHIFT of a cnt-4 job -> no done pulse, next cycle IDLE/outputs 0. A fresh req0 job then completes normally.

Source files
------------

// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the 4-bit shift-register sequencer.
// The job record captures a request at accept time with its count already clamped.
package shift_reg_pkg;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  localparam logic DIR_RIGHT = 1'b0;
  localparam logic DIR_LEFT  = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             dir;
    logic [CNT_W-1:0] cnt;
    logic             fill;
    logic             id;
  } job_t;

  // Shifting more than WIDTH times gives the same result as WIDTH shifts.
  function automatic logic [CNT_W-1:0] clamp_cnt(input logic [CNT_W-1:0] cnt);
    logic [CNT_W-1:0] lim;
    lim = CNT_W'(WIDTH);
    if (cnt > lim) begin
      clamp_cnt = lim;
    end else begin
      clamp_cnt = cnt;
    end
  endfunction

  function automatic job_t make_job(
    input logic [WIDTH-1:0] data,
    input logic             dir,
    input logic [CNT_W-1:0] cnt,
    input logic             fill,
    input logic             id
  );
    job_t j;
    j.data = data;
    j.dir  = dir;
    j.cnt  = clamp_cnt(cnt);
    j.fill = fill;
    j.id   = id;
    return j;
  endfunction

endpackage

// File: rtl/shift_reg_seq_ctrl_if.sv
// Bundle of the two requester channels, the shift-register control bus and the result.
// slave = sequencer view, master = client plus register view.
interface shift_reg_seq_ctrl_if;
  import shift_reg_pkg::*;

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_data;
  logic             req0_dir;
  logic [CNT_W-1:0] req0_cnt;
  logic             req0_fill;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_data;
  logic             req1_dir;
  logic [CNT_W-1:0] req1_cnt;
  logic             req1_fill;

  logic [WIDTH-1:0] sr_l;
  logic             sr_ld;
  logic             sr_r;
  logic             sr_lf;
  logic             sr_d;
  logic [WIDTH-1:0] sr_q;

  logic             busy;
  logic             done;
  logic             done_id;
  logic [WIDTH-1:0] dout;

  modport slave (
    input  req0_valid, req0_data, req0_dir, req0_cnt, req0_fill,
    input  req1_valid, req1_data, req1_dir, req1_cnt, req1_fill,
    output req0_ready, req1_ready,
    output sr_l, sr_ld, sr_r, sr_lf, sr_d,
    input  sr_q,
    output busy, done, done_id, dout
  );

  modport master (
    output req0_valid, req0_data, req0_dir, req0_cnt, req0_fill,
    output req1_valid, req1_data, req1_dir, req1_cnt, req1_fill,
    input  req0_ready, req1_ready,
    input  sr_l, sr_ld, sr_r, sr_lf, sr_d,
    output sr_q,
    input  busy, done, done_id, dout
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the pointer flips to the other side on every accept.
// A grant is only issued while en is high, so a grant is an accept.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic valid0,
  input  logic valid1,
  output logic grant0,
  output logic grant1
);

  logic prio_r;
  logic pick1_s;

  // Pick a side: a lone requester wins, a tie goes to the pointer.
  always_comb begin
    pick1_s = 1'b0;
    if (valid0 && valid1) begin
      pick1_s = prio_r;
    end else if (valid1) begin
      pick1_s = 1'b1;
    end else begin
      pick1_s = 1'b0;
    end
    grant0 = en && valid0 && !pick1_s;
    grant1 = en && valid1 && pick1_s;
  end

  // Priority pointer: favour the side that was not just served.
  always_ff @(posedge clk) begin
    if (rst) begin
      prio_r <= 1'b0;
    end else if (grant0) begin
      prio_r <= 1'b1;
    end else if (grant1) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

endmodule

// File: rtl/shift_reg_4b.sv
// 4-bit parallel-load, bidirectional shift register driven by the sequencer's sr_* bus.
// Load has priority over right shift, right over left.
module shift_reg_4b
  import shift_reg_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] l,
  input  logic             ld,
  input  logic             r,
  input  logic             lf,
  input  logic             d,
  output logic [WIDTH-1:0] q
);

  // Register update: load, shift right (d enters MSB), shift left (d enters LSB).
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else if (ld) begin
      q <= l;
    end else if (r) begin
      q <= {d, q[WIDTH-1:1]};
    end else if (lf) begin
      q <= {q[WIDTH-2:0], d};
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/shift_reg_seq_ctrl.sv
// Sequencer for the 4-bit shift register: arbitrates two job sources, then loads,
// shifts cnt times and reports the final register value with a one-cycle done pulse.
module shift_reg_seq_ctrl
  import shift_reg_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  shift_reg_seq_ctrl_if.slave  bus
);

  state_t           state_r;
  state_t           state_s;
  job_t             job_r;
  job_t             job_s;
  logic [CNT_W-1:0] rem_r;
  logic [CNT_W-1:0] rem_s;

  logic             arb_en_s;
  logic             grant0_s;
  logic             grant1_s;

  logic             sr_ld_r;
  logic             sr_r_r;
  logic             sr_lf_r;
  logic             sr_d_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] dout_r;

  // Reset wins over a same-cycle accept, so the arbiter is muted while rst is high.
  assign arb_en_s = (state_r == IDLE) && !rst;

  rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .en     (arb_en_s),
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  assign bus.req0_ready = grant0_s;
  assign bus.req1_ready = grant1_s;

  // Next state, job capture and remaining-shift count.
  always_comb begin
    state_s = state_r;
    job_s   = job_r;
    rem_s   = rem_r;
    case (state_r)
      IDLE: begin
        if (grant0_s) begin
          job_s   = make_job(bus.req0_data, bus.req0_dir, bus.req0_cnt, bus.req0_fill, 1'b0);
          state_s = LOAD;
        end else if (grant1_s) begin
          job_s   = make_job(bus.req1_data, bus.req1_dir, bus.req1_cnt, bus.req1_fill, 1'b1);
          state_s = LOAD;
        end else begin
          state_s = IDLE;
        end
      end
      LOAD: begin
        rem_s = job_r.cnt;
        if (job_r.cnt != {CNT_W{1'b0}}) begin
          state_s = SHIFT;
        end else begin
          state_s = DONE;
        end
      end
      SHIFT: begin
        rem_s = rem_r - CNT_W'(1);
        if (rem_r == CNT_W'(1)) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, job and count registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      job_r   <= '0;
      rem_r   <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_s;
      job_r   <= job_s;
      rem_r   <= rem_s;
    end
  end

  // Outputs are registered from the next state so each strobe lines up with its state.
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_ld_r <= 1'b0;
      sr_r_r  <= 1'b0;
      sr_lf_r <= 1'b0;
      sr_d_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      sr_ld_r <= (state_s == LOAD);
      sr_r_r  <= (state_s == SHIFT) && (job_s.dir == DIR_RIGHT);
      sr_lf_r <= (state_s == SHIFT) && (job_s.dir == DIR_LEFT);
      sr_d_r  <= (state_s == SHIFT) && job_s.fill;
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // In DONE the register already holds the result of the last load or shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout_r <= {WIDTH{1'b0}};
    end else if (state_r == DONE) begin
      dout_r <= bus.sr_q;
    end else begin
      dout_r <= dout_r;
    end
  end

  assign bus.sr_l    = job_r.data;
  assign bus.sr_ld   = sr_ld_r;
  assign bus.sr_r    = sr_r_r;
  assign bus.sr_lf   = sr_lf_r;
  assign bus.sr_d    = sr_d_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.done_id = job_r.id;
  assign bus.dout    = dout_r;

endmodule

// File: tb/tb_shift_reg_seq_ctrl.sv
// Bench for shift_reg_seq_ctrl with a real shift_reg_4b on the sr_* bus; a job-level
// model predicts every output each cycle, and directed jobs pin results to literals.
module tb_shift_reg_seq_ctrl;
  import shift_reg_pkg::*;

  typedef struct {
    logic [3:0] data;
    logic       dir;
    logic [2:0] cnt;
    logic       fill;
  } tb_job_t;

  logic       clk;
  logic       rst;
  logic       reg_rst;
  logic       v   [2];
  logic [3:0] dat [2];
  logic       dr  [2];
  logic [2:0] cn  [2];
  logic       fl  [2];

  tb_job_t q0[$];
  tb_job_t q1[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit cmp_en = 1'b0;
  int done_cnt = 0;
  int last_done_cyc = 0;
  int last_done_id = 0;
  int done_ids[$];
  int n_ld = 0;
  int n_r = 0;
  int n_lf = 0;

  // job-level model state
  bit         m_active = 1'b0;
  int         m_k = 0;
  int         m_cnt = 0;
  logic       m_dir = 1'b0;
  logic       m_fill = 1'b0;
  logic       m_id = 1'b0;
  logic       m_prio = 1'b0;
  logic [3:0] m_data = 4'd0;
  logic [3:0] m_dout = 4'd0;
  int         m_acc_cyc = 0;
  logic e_r0, e_r1, e_busy, e_ld, e_r, e_lf, e_d, e_done;

  shift_reg_seq_ctrl_if bus();

  shift_reg_seq_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  shift_reg_4b u_reg (
    .clk (clk),
    .rst (reg_rst),
    .l   (bus.sr_l),
    .ld  (bus.sr_ld),
    .r   (bus.sr_r),
    .lf  (bus.sr_lf),
    .d   (bus.sr_d),
    .q   (bus.sr_q)
  );

  assign bus.req0_valid = v[0];
  assign bus.req0_data  = dat[0];
  assign bus.req0_dir   = dr[0];
  assign bus.req0_cnt   = cn[0];
  assign bus.req0_fill  = fl[0];
  assign bus.req1_valid = v[1];
  assign bus.req1_data  = dat[1];
  assign bus.req1_dir   = dr[1];
  assign bus.req1_cnt   = cn[1];
  assign bus.req1_fill  = fl[1];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Final word after n shifts, straight from the register semantics.
  function automatic logic [3:0] shift_result(input logic [3:0] w, input logic dir,
                                              input int n, input logic fill);
    logic [3:0] x;
    x = w;
    for (int i = 0; i < n; i++) begin
      if (dir) x = (x << 1) | {3'b000, fill};
      else     x = (x >> 1) | {fill, 3'b000};
    end
    return x;
  endfunction

  function automatic logic rdy(input int r);
    return (r == 1) ? bus.req1_ready : bus.req0_ready;
  endfunction

  // Requester driver: present a queued job, hold it until accepted, then scramble the fields.
  task automatic drv(input int r);
    tb_job_t j;
    int n;
    forever begin
      @(posedge clk);
      if ((r == 0 && q0.size() > 0) || (r == 1 && q1.size() > 0)) begin
        if (r == 0) j = q0.pop_front();
        else        j = q1.pop_front();
        #1;
        dat[r] = j.data; dr[r] = j.dir; cn[r] = j.cnt; fl[r] = j.fill; v[r] = 1'b1;
        n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (!rdy(r) && n < 400);
        check((r == 0) ? "req0_accept" : "req1_accept", rdy(r), 1);
        @(posedge clk);
        #1;
        v[r] = 1'b0; dat[r] = ~j.data; dr[r] = ~j.dir; cn[r] = 3'd5; fl[r] = ~j.fill;
      end
    end
  endtask

  initial drv(0);
  initial drv(1);

  // Per-cycle compare against the model, then advance the model across the next edge.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        e_r0 = 1'b0; e_r1 = 1'b0; e_busy = 1'b0; e_ld = 1'b0;
        e_r = 1'b0; e_lf = 1'b0; e_d = 1'b0; e_done = 1'b0;
        if (m_active) begin
          e_busy = 1'b1;
          if (m_k == 1) e_ld = 1'b1;
          else if (m_k <= m_cnt + 1) begin
            e_r = !m_dir; e_lf = m_dir; e_d = m_fill;
          end else e_done = 1'b1;
        end else begin
          e_r0 = !rst && v[0] && (!v[1] || !m_prio);
          e_r1 = !rst && v[1] && (!v[0] || m_prio);
        end
        check("req0_ready", bus.req0_ready, e_r0);
        check("req1_ready", bus.req1_ready, e_r1);
        check("busy", bus.busy, e_busy);
        check("sr_ld", bus.sr_ld, e_ld);
        check("sr_r", bus.sr_r, e_r);
        check("sr_lf", bus.sr_lf, e_lf);
        check("sr_d", bus.sr_d, e_d);
        check("sr_l", bus.sr_l, m_data);
        check("done", bus.done, e_done);
        check("done_id", bus.done_id, m_id);
        check("dout", bus.dout, m_dout);
        check("ctrl_overlap", int'(bus.sr_ld) + int'(bus.sr_r) + int'(bus.sr_lf) > 1, 0);
        n_ld += int'(bus.sr_ld); n_r += int'(bus.sr_r); n_lf += int'(bus.sr_lf);
        if (bus.done) begin
          done_cnt++;
          last_done_cyc = cyc;
          last_done_id = int'(bus.done_id);
          done_ids.push_back(int'(bus.done_id));
        end
        if (rst) begin
          m_active = 1'b0; m_prio = 1'b0; m_data = 4'd0; m_id = 1'b0; m_dout = 4'd0;
        end else if (!m_active) begin
          if (v[0] || v[1]) begin
            m_id = e_r0 ? 1'b0 : 1'b1;
            m_data = dat[m_id]; m_dir = dr[m_id]; m_fill = fl[m_id];
            m_cnt = (cn[m_id] > 3'd4) ? 4 : int'(cn[m_id]);
            m_prio = !m_id; m_active = 1'b1; m_k = 1; m_acc_cyc = cyc;
          end
        end else if (m_k == m_cnt + 2) begin
          m_active = 1'b0;
          m_dout = shift_result(m_data, m_dir, m_cnt, m_fill);
        end else begin
          m_k++;
        end
      end
    end
  end

  task automatic wait_dones(input int target, input string tag);
    for (int i = 0; i < 500 && done_cnt < target; i++) @(posedge clk);
    check({tag, "_done_seen"}, done_cnt, target);
  endtask

  task automatic run_job(input int r, input tb_job_t j, input string tag,
                         input logic [3:0] exp_dout, input int exp_lat,
                         input int exp_ld, input int exp_r, input int exp_lf);
    int dc;
    @(negedge clk);
    dc = done_cnt; n_ld = 0; n_r = 0; n_lf = 0;
    if (r == 0) q0.push_back(j);
    else        q1.push_back(j);
    wait_dones(dc + 1, tag);
    @(negedge clk);
    #1;
    check({tag, "_dout"}, bus.dout, exp_dout);
    check({tag, "_done_id"}, last_done_id, r);
    check({tag, "_latency"}, last_done_cyc - m_acc_cyc, exp_lat);
    check({tag, "_n_ld"}, n_ld, exp_ld);
    check({tag, "_n_r"}, n_r, exp_r);
    check({tag, "_n_lf"}, n_lf, exp_lf);
  endtask

  initial begin
    int dc;
    int n;
    rst = 1'b1; reg_rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      v[i] = 1'b0; dat[i] = 4'd0; dr[i] = 1'b0; cn[i] = 3'd0; fl[i] = 1'b0;
    end
    @(posedge clk);
    #1;
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dout", bus.dout, 0);
    check("rst_sr_ctrl", {bus.sr_ld, bus.sr_r, bus.sr_lf, bus.sr_d}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0; reg_rst = 1'b0;
    @(negedge clk);
    check("idle_ready", {bus.req0_ready, bus.req1_ready}, 0);
    check("idle_busy", bus.busy, 0);

    run_job(0, '{4'b1011, 1'b0, 3'd2, 1'b0}, "r0_right2", 4'b0010, 4, 1, 2, 0);
    run_job(1, '{4'b1011, 1'b1, 3'd1, 1'b1}, "r1_left1", 4'b0111, 3, 1, 0, 1);
    run_job(1, '{4'b1011, 1'b1, 3'd7, 1'b1}, "r1_clamp7", 4'b1111, 6, 1, 0, 4);
    run_job(0, '{4'b0110, 1'b0, 3'd0, 1'b1}, "r0_cnt0", 4'b0110, 2, 1, 0, 0);

    // Reset returns the pointer to requester 0, then both sides compete for 4 jobs each.
    @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    dc = done_cnt; n_ld = 0;
    done_ids.delete();
    q0.push_back('{4'b0011, 1'b0, 3'd1, 1'b1});
    q0.push_back('{4'b1100, 1'b1, 3'd2, 1'b0});
    q0.push_back('{4'b1111, 1'b0, 3'd3, 1'b0});
    q0.push_back('{4'b0001, 1'b1, 3'd0, 1'b1});
    q1.push_back('{4'b1010, 1'b1, 3'd1, 1'b0});
    q1.push_back('{4'b0110, 1'b0, 3'd2, 1'b1});
    q1.push_back('{4'b1001, 1'b1, 3'd5, 1'b1});
    q1.push_back('{4'b0100, 1'b0, 3'd4, 1'b0});
    wait_dones(dc + 8, "alt");
    for (int i = 0; i < 8; i++) begin
      check("alt_order", (i < done_ids.size()) ? done_ids[i] : -1, i % 2);
    end
    check("alt_n_ld", n_ld, 8);

    // Reset in the middle of a 4-shift job discards it without a done pulse.
    @(negedge clk);
    dc = done_cnt;
    q0.push_back('{4'b1001, 1'b0, 3'd4, 1'b1});
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.sr_r && n < 100);
    check("rst_wait_shift", bus.sr_r, 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_busy", bus.busy, 0);
    check("midrst_sr_r", bus.sr_r, 0);
    check("midrst_sr_l", bus.sr_l, 0);
    check("midrst_dout", bus.dout, 0);
    repeat (6) @(posedge clk);
    check("midrst_no_done", done_cnt, dc);
    run_job(0, '{4'b0101, 1'b1, 3'd3, 1'b0}, "post_rst", 4'b1000, 5, 1, 0, 3);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
